// File: rtl/lr_pkg.sv
// Shared types and geometry for the line-buffer window front end.
package lr_pkg;

  localparam int PIX_W    = 7;
  localparam int WIN_ROWS = 8;
  localparam int WIN_COLS = 10;
  localparam int NFEAT    = 81;
  localparam int N_LINES  = WIN_ROWS - 1;

  typedef logic [PIX_W-1:0] pix_t;

  localparam pix_t BIAS_FEAT = 7'd1;

  // Slot 0 of the feature vector is the bias, so window cells start at 1.
  function automatic int feat_idx(input int r, input int c);
    return 1 + WIN_COLS * r + c;
  endfunction

endpackage

// File: rtl/linebuffer_window_if.sv
// Raster pixel stream from the sensor side into the window generator.
interface linebuffer_window_if;
  import lr_pkg::*;

  pix_t pix_in;
  logic pix_valid;
  logic sof;

  modport master (output pix_in, output pix_valid, output sof);
  modport slave  (input  pix_in, input  pix_valid, input  sof);

endinterface

// File: rtl/linebuf_line.sv
// One image line of pixel delay, advancing only on en; storage is a plain
// synchronous-read memory plus the output register, totalling DEPTH samples.
module linebuf_line
  import lr_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  pix_t din,
  output pix_t dout
);

  localparam int MEM_D = DEPTH - 1;
  localparam int AW    = (MEM_D > 1) ? $clog2(MEM_D) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(MEM_D - 1);

  pix_t          mem [MEM_D];
  logic [AW-1:0] ptr;

  // Read-before-write: dout picks up the sample written MEM_D accepts ago.
  always_ff @(posedge clk) begin
    if (en) begin
      dout     <= mem[ptr];
      mem[ptr] <= din;
    end
  end

  // Circular write/read pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/linebuffer_window.sv
// 8x10 sliding window over a raster pixel stream, presented as an 81-entry
// feature vector (bias + window) for the downstream inner-product stage.
module linebuffer_window
  import lr_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  linebuffer_window_if.slave   pix_if,
  output pix_t                 xarray [0:NFEAT-1],
  output logic                 win_valid,
  output logic [9:0]           win_row,
  output logic [9:0]           win_col,
  output logic                 frame_done
);

  localparam logic [9:0] COL_LAST  = 10'(IMG_W - 1);
  localparam logic [9:0] ROW_LAST  = 10'(IMG_H - 1);
  localparam logic [9:0] ROW_FIRST = 10'(WIN_ROWS - 1);
  localparam logic [9:0] COL_FIRST = 10'(WIN_COLS - 1);

  logic       accept;
  logic       line_en;
  logic [9:0] col;
  logic [9:0] row;
  logic [9:0] cur_col;
  logic [9:0] cur_row;

  pix_t line_in  [N_LINES];
  pix_t line_out [N_LINES];
  pix_t tap      [WIN_ROWS];
  pix_t win      [WIN_ROWS][WIN_COLS];

  assign accept  = pix_if.pix_valid;
  assign line_en = pix_if.pix_valid & ~rst;

  // Position of the pixel being accepted; sof restarts the frame at (0,0).
  always_comb begin
    cur_col = col;
    cur_row = row;
    if (pix_if.sof) begin
      cur_col = 10'd0;
      cur_row = 10'd0;
    end else begin
      cur_col = col;
      cur_row = row;
    end
  end

  // Line chain: line 0 sees the live stream, each later line delays the previous.
  always_comb begin
    for (int i = 0; i < N_LINES; i++) begin
      line_in[i] = (i == 0) ? pix_if.pix_in : line_out[(i > 0) ? i - 1 : 0];
    end
  end

  for (genvar g = 0; g < N_LINES; g++) begin : g_line
    linebuf_line #(.DEPTH(IMG_W)) u_line (
      .clk  (clk),
      .rst  (rst),
      .en   (line_en),
      .din  (line_in[g]),
      .dout (line_out[g])
    );
  end

  // Window row r=7 is the live line; row 0 is the oldest delayed line.
  always_comb begin
    tap[WIN_ROWS-1] = pix_if.pix_in;
    for (int r = 0; r < WIN_ROWS - 1; r++) begin
      tap[r] = line_out[WIN_ROWS - 2 - r];
    end
  end

  // Window shift register, one column per accepted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < WIN_ROWS; r++) begin
        for (int c = 0; c < WIN_COLS; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < WIN_ROWS; r++) begin
        for (int c = 0; c < WIN_COLS - 1; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][WIN_COLS-1] <= tap[r];
      end
    end
  end

  // Raster counters and the registered window/frame qualifiers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= 10'd0;
      row        <= 10'd0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_row    <= 10'd0;
      win_col    <= 10'd0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (accept) begin
        if (cur_col == COL_LAST) begin
          col <= 10'd0;
          row <= (cur_row == ROW_LAST) ? 10'd0 : cur_row + 10'd1;
        end else begin
          col <= cur_col + 10'd1;
          row <= cur_row;
        end
        frame_done <= (cur_col == COL_LAST) && (cur_row == ROW_LAST);
        // Requiring col >= 9 keeps every window inside a single line.
        if ((cur_row >= ROW_FIRST) && (cur_col >= COL_FIRST)) begin
          win_valid <= 1'b1;
          win_row   <= cur_row - ROW_FIRST;
          win_col   <= cur_col - COL_FIRST;
        end
      end
    end
  end

  // Flatten the registered window behind the constant bias slot.
  always_comb begin
    xarray[0] = BIAS_FEAT;
    for (int r = 0; r < WIN_ROWS; r++) begin
      for (int c = 0; c < WIN_COLS; c++) begin
        xarray[feat_idx(r, c)] = win[r][c];
      end
    end
  end

endmodule

// File: tb/tb_linebuffer_window.sv
// Directed bench for linebuffer_window on a 16x10 frame, pixel(r,c) = (16r+c) mod 128.
module tb_linebuffer_window;
  import lr_pkg::*;

  localparam int W = 16;
  localparam int H = 10;

  logic       clk;
  logic       rst;
  logic [6:0] xarray [0:80];
  logic       win_valid;
  logic [9:0] win_row;
  logic [9:0] win_col;
  logic       frame_done;

  int checks;
  int failures;
  int wins;
  int fds;

  linebuffer_window_if pif ();

  linebuffer_window #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_if     (pif),
    .xarray     (xarray),
    .win_valid  (win_valid),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] pv(input int r, input int c);
    int v;
    v = (16 * r + c) % 128;
    return v[6:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [6:0] p, input logic v, input logic s);
    @(negedge clk);
    pif.pix_in    = p;
    pif.pix_valid = v;
    pif.sof       = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state();
    chk("rst_win_valid", {31'd0, win_valid}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_win_row", {22'd0, win_row}, 32'd0);
    chk("rst_win_col", {22'd0, win_col}, 32'd0);
    chk("rst_bias", {25'd0, xarray[0]}, 32'd1);
    for (int i = 1; i < 81; i++) chk("rst_xarray", {25'd0, xarray[i]}, 32'd0);
  endtask

  task automatic send_pixel(input int r, input int c, input logic s);
    logic ev;
    step(pv(r, c), 1'b1, s);
    ev = (r >= 7) && (c >= 9);
    if (frame_done) fds++;
    chk("win_valid", {31'd0, win_valid}, {31'd0, ev});
    chk("frame_done", {31'd0, frame_done}, {31'd0, (r == H - 1) && (c == W - 1)});
    chk("bias", {25'd0, xarray[0]}, 32'd1);
    chk("x80_newest", {25'd0, xarray[80]}, {25'd0, pv(r, c)});
    if (ev) begin
      wins++;
      chk("win_row", {22'd0, win_row}, 32'(r - 7));
      chk("win_col", {22'd0, win_col}, 32'(c - 9));
      for (int rr = 0; rr < 8; rr++) begin
        for (int cc = 0; cc < 10; cc++) begin
          chk("window", {25'd0, xarray[1 + 10 * rr + cc]}, {25'd0, pv(r - 7 + rr, c - 9 + cc)});
        end
      end
    end
  endtask

  task automatic gap_cycle(input logic s);
    logic [6:0] h1, h80;
    logic [9:0] hr, hc;
    h1  = xarray[1];
    h80 = xarray[80];
    hr  = win_row;
    hc  = win_col;
    step(7'd99, 1'b0, s);
    chk("gap_win_valid", {31'd0, win_valid}, 32'd0);
    chk("gap_frame_done", {31'd0, frame_done}, 32'd0);
    chk("gap_hold_x1", {25'd0, xarray[1]}, {25'd0, h1});
    chk("gap_hold_x80", {25'd0, xarray[80]}, {25'd0, h80});
    chk("gap_hold_row", {22'd0, win_row}, {22'd0, hr});
    chk("gap_hold_col", {22'd0, win_col}, {22'd0, hc});
  endtask

  // Sends the first n pixels of a frame in raster order, sof on the first.
  task automatic frame(input int n, input bit gaps);
    wins = 0;
    fds  = 0;
    for (int k = 0; k < n; k++) begin
      send_pixel(k / W, k % W, k == 0);
      if (gaps) gap_cycle(k % 3 == 0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    wins     = 0;
    fds      = 0;
    rst           = 1'b1;
    pif.pix_in    = 7'd5;
    pif.pix_valid = 1'b1;
    pif.sof       = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset_state();
    @(negedge clk);
    rst           = 1'b0;
    pif.pix_valid = 1'b0;
    pif.sof       = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_state();

    // Full frame, continuous valid
    frame(W * H, 1'b0);
    chk("full_wins", 32'(wins), 32'd21);
    chk("full_fd", 32'(fds), 32'd1);

    // Same frame with a gap after every pixel, sof sometimes raised in gaps
    frame(W * H, 1'b1);
    chk("gap_wins", 32'(wins), 32'd21);
    chk("gap_fd", 32'(fds), 32'd1);

    // Partial frame up to (8,3), then reset
    frame(8 * W + 4, 1'b0);
    chk("partial_wins", 32'(wins), 32'd7);
    chk("partial_fd", 32'(fds), 32'd0);
    @(negedge clk);
    rst           = 1'b1;
    pif.pix_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_state();
    @(negedge clk);
    rst = 1'b0;
    frame(W * H, 1'b0);
    chk("after_rst_wins", 32'(wins), 32'd21);
    chk("after_rst_fd", 32'(fds), 32'd1);

    // Abandon at (5,4) with a new sof
    frame(5 * W + 4, 1'b0);
    chk("abandon_fd", 32'(fds), 32'd0);
    frame(W * H, 1'b0);
    chk("restart_wins", 32'(wins), 32'd21);
    chk("restart_fd", 32'(fds), 32'd1);

    // Back-to-back frames
    frame(W * H, 1'b0);
    chk("b2b1_wins", 32'(wins), 32'd21);
    chk("b2b1_fd", 32'(fds), 32'd1);
    frame(W * H, 1'b0);
    chk("b2b2_wins", 32'(wins), 32'd21);
    chk("b2b2_fd", 32'(fds), 32'd1);

    step(7'd0, 1'b0, 1'b0);
    chk("idle_frame_done", {31'd0, frame_done}, 32'd0);
    chk("idle_win_valid", {31'd0, win_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/linebuffer_window.md
LINEBUFFER_WINDOW -- requirements
Module: linebuffer_window

Interface
REQ-001 Parameter IMG_W, default 64, pixels per image line (10..1024).
REQ-002 Parameter IMG_H, default 48, lines per frame (8..1024).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 pix_in  input  7  unsigned pixel value, raster order.
REQ-006 pix_valid  input  1  pix_in accepted on this cycle; no backpressure.
REQ-007 sof  input  1  start of frame, qualified by pix_valid; this pixel is (row 0, col 0).
REQ-008 xarray  output  7 x [0:80] unpacked  feature window for the inner-product stage.
REQ-009 win_valid  output  1  one-cycle pulse: xarray holds a complete new window.
REQ-010 win_row  output  10  frame row of the window's top line.
REQ-011 win_col  output  10  frame column of the window's left pixel.
REQ-012 frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-013 The window SHALL be 8 rows x 10 columns; xarray[1+10*r+c] = pixel(newest_row-7+r, newest_col-9+c), with r=0 the oldest line and c=0 the oldest column.
REQ-014 xarray[0] SHALL be constant 7'd1 (bias slot, never driven from pixels).
REQ-015 The block SHALL hold 7 line delays of IMG_W pixels each plus an 8x10 shift-register window; a delay line advances only on pix_valid.
REQ-016 Column counter SHALL run 0..IMG_W-1; at IMG_W-1 with pix_valid it SHALL wrap to 0 and increment the row counter.
REQ-017 Row counter SHALL run 0..IMG_H-1; accepting pixel (IMG_H-1, IMG_W-1) SHALL clear both counters and pulse frame_done on the next cycle.
REQ-018 win_valid SHALL pulse in the cycle after acceptance of pixel (row, col) iff row>=7 and col>=9; windows never span a line wrap.
REQ-019 Latency: pixel accepted at cycle t appears in xarray[80] and win_valid at t+1; xarray SHALL hold its value until the next accepted pixel.
REQ-020 win_row = row-7 and win_col = col-9 of the newest pixel, registered with win_valid.
REQ-021 pix_valid low: no state change; counters, window and outputs hold; win_valid and frame_done low.
REQ-022 sof with pix_valid SHALL force counters to (0,0) before accepting that pixel, regardless of current position; a partial previous frame is abandoned without frame_done.
REQ-023 sof without pix_valid SHALL be ignored.
REQ-024 Windows per frame SHALL equal (IMG_W-9)*(IMG_H-7).

Reset
REQ-025 On rst: counters 0, win_valid 0, frame_done 0, win_row 0, win_col 0, xarray[1..80] 0, xarray[0] 1.
REQ-026 Line-delay storage SHALL NOT require reset; reset gating of win_valid via counters prevents stale data from being flagged valid.
REQ-027 rst SHALL take priority over pix_valid and sof in the same cycle.

Structure
REQ-028 Shared package lr_pkg SHALL hold PIX_W=7, WIN_ROWS=8, WIN_COLS=10, NFEAT=81 and the pixel typedef.
REQ-029 One sub-module linebuf_line (single IMG_W-deep pixel delay, enable-gated, inferable as RAM) SHALL be instantiated 7 times.
REQ-030 Output ports SHALL connect directly to the existing inner-product stage's xarray input without adaptation.

Verification (IMG_W=16, IMG_H=10, pixel(r,c) = (16r+c) mod 128)
REQ-031 Full frame, pix_valid constant -> first win_valid one cycle after pixel (7,9): xarray[1]=0, xarray[80]=121, win_row=0, win_col=0; exactly 21 pulses; frame_done once.
REQ-032 Same frame with pix_valid low every other cycle -> identical xarray sequence and 21 pulses; outputs hold during gaps.
REQ-033 Check window at pixel (9,15) -> xarray[1]=(16*2+6)=38, xarray[80]=159 mod 128=31, win_row=2, win_col=6.
REQ-034 rst asserted after pixel (8,3), then new frame with sof -> no win_valid until (7,9) of new frame; xarray[0]=1 throughout.
REQ-035 sof at pixel (5,4) mid-frame -> counters restart, no frame_done for the abandoned frame, next win_valid after new (7,9).
REQ-036 Back-to-back frames with sof on each first pixel -> 21 windows and one frame_done per frame, no gap cycles required.
